spi_shift_engine: RTL and testbench

Bit-level SPI physical stage that sits directly downstream of the byte-level SPI master controller. It accepts one byte plus a 3-bit slave select code per START, and serializes the byte MSB-first on MOSI in SPI mode 0 (CPOL=0, CPHA=0) at a divided SCLK rate. It drives one active-low chip select per slave and captures 8 bits from MISO. It returns the received byte with a one-cycle valid strobe.

---
 rtl/spi_shift_engine.sv | 181 ++++++++++++++++++
 tb/tb_spi_shift_engine.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_shift_engine.sv
// spi_shift_engine
// Bit-level SPI mode 0 (CPOL=0, CPHA=0) shifter. It takes one byte and a
// slave-select code per accepted start, clocks the byte out MSB-first on MOSI
// at a divided SCLK rate, captures eight MISO bits on the SCLK rising edges,
// and returns the received byte with a one-cycle valid strobe.
//
// Ports:
//   i_clk       system clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   i_start     transfer request, only looked at while idle
//   i_ss_in     slave select code, latched on accept
//   i_tx_data   byte to send, latched on accept
//   i_miso      serial data from the slave
//   o_sclk      SPI clock
//   o_mosi      serial data to the slave
//   o_ss_n      active-low chip selects, bit i belongs to code i
//   o_rx_data   last received byte
//   o_rx_valid  one-cycle strobe when o_rx_data has been updated
//   o_busy      high whenever the engine is not idle
//   o_sel_err   one-cycle strobe for a start with an out-of-range code
module spi_shift_engine #(
  parameter int CLK_DIV    = 4,
  parameter int NUM_SLAVES = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [2:0]            i_ss_in,
  input  logic [7:0]            i_tx_data,
  input  logic                  i_miso,
  output logic                  o_sclk,
  output logic                  o_mosi,
  output logic [NUM_SLAVES-1:0] o_ss_n,
  output logic [7:0]            o_rx_data,
  output logic                  o_rx_valid,
  output logic                  o_busy,
  output logic                  o_sel_err
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_DONE} state_t;

  // The divider also times the hold phase, which spans two half-periods.
  localparam int CNT_W = $clog2(2 * CLK_DIV + 1);

  state_t                r_state, w_stateNext;
  logic [CNT_W-1:0]      r_divCnt, w_divCntNext;
  logic [2:0]            r_bitCnt, w_bitCntNext;
  logic [7:0]            r_txShift, w_txShiftNext;
  logic [7:0]            r_rxShift, w_rxShiftNext;
  logic                  w_sclkNext, w_mosiNext, w_rxValidNext, w_busyNext, w_selErrNext;
  logic [NUM_SLAVES-1:0] w_ssNNext;
  logic [7:0]            w_rxDataNext;
  logic                  w_selValid, w_accept, w_halfDone, w_holdDone;

  assign w_selValid = (32'(i_ss_in) < NUM_SLAVES);
  assign w_accept   = (r_state == S_IDLE) && i_start && w_selValid;
  // With a divide of one every cycle ends a half-period, so the count is ignored.
  assign w_halfDone = (CLK_DIV == 1) ? 1'b1 : (r_divCnt == CNT_W'(CLK_DIV - 1));
  assign w_holdDone = (r_divCnt == CNT_W'(2 * CLK_DIV - 1));

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_stateNext;
  end

  // Next-state logic
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_stateNext = S_SETUP;
      S_SETUP: if (w_halfDone) w_stateNext = S_SHIFT;
      // Leave SHIFT on the falling SCLK edge that ends the eighth bit.
      S_SHIFT: if (w_halfDone && o_sclk && (r_bitCnt == 3'd7)) w_stateNext = S_HOLD;
      S_HOLD:  if (w_holdDone) w_stateNext = S_DONE;
      S_DONE:  w_stateNext = S_IDLE;
      default: w_stateNext = S_IDLE;
    endcase
  end

  // Output and datapath next values; everything is registered below.
  always_comb begin
    w_divCntNext  = r_divCnt;
    w_bitCntNext  = r_bitCnt;
    w_txShiftNext = r_txShift;
    w_rxShiftNext = r_rxShift;
    w_sclkNext    = o_sclk;
    w_mosiNext    = o_mosi;
    w_ssNNext     = o_ss_n;
    w_rxDataNext  = o_rx_data;
    w_rxValidNext = 1'b0;
    w_selErrNext  = 1'b0;
    w_busyNext    = (w_stateNext != S_IDLE);
    case (r_state)
      S_IDLE: begin
        w_divCntNext = '0;
        w_bitCntNext = '0;
        if (i_start) begin
          if (w_selValid) begin
            w_txShiftNext = i_tx_data;
            w_mosiNext    = i_tx_data[7];
            w_ssNNext     = ~(NUM_SLAVES'(1) << i_ss_in);
          end else begin
            w_selErrNext = 1'b1;
          end
        end
      end
      S_SETUP: begin
        if (w_halfDone) begin
          w_divCntNext  = '0;
          w_sclkNext    = 1'b1;
          w_rxShiftNext = {r_rxShift[6:0], i_miso};
        end else begin
          w_divCntNext = r_divCnt + 1'b1;
        end
      end
      S_SHIFT: begin
        if (w_halfDone) begin
          w_divCntNext = '0;
          if (o_sclk) begin
            w_sclkNext    = 1'b0;
            w_bitCntNext  = r_bitCnt + 1'b1;
            w_mosiNext    = (r_bitCnt == 3'd7) ? 1'b0 : r_txShift[6];
            w_txShiftNext = {r_txShift[6:0], 1'b0};
          end else begin
            w_sclkNext    = 1'b1;
            w_rxShiftNext = {r_rxShift[6:0], i_miso};
          end
        end else begin
          w_divCntNext = r_divCnt + 1'b1;
        end
      end
      S_HOLD: begin
        if (w_holdDone) begin
          w_divCntNext  = '0;
          w_ssNNext     = '1;
          w_rxDataNext  = r_rxShift;
          w_rxValidNext = 1'b1;
        end else begin
          w_divCntNext = r_divCnt + 1'b1;
        end
      end
      S_DONE: begin
        w_divCntNext = '0;
      end
      default: begin
        w_divCntNext = '0;
      end
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_divCnt   <= '0;
      r_bitCnt   <= '0;
      r_txShift  <= '0;
      r_rxShift  <= '0;
      o_sclk     <= 1'b0;
      o_mosi     <= 1'b0;
      o_ss_n     <= '1;
      o_rx_data  <= '0;
      o_rx_valid <= 1'b0;
      o_busy     <= 1'b0;
      o_sel_err  <= 1'b0;
    end else begin
      r_divCnt   <= w_divCntNext;
      r_bitCnt   <= w_bitCntNext;
      r_txShift  <= w_txShiftNext;
      r_rxShift  <= w_rxShiftNext;
      o_sclk     <= w_sclkNext;
      o_mosi     <= w_mosiNext;
      o_ss_n     <= w_ssNNext;
      o_rx_data  <= w_rxDataNext;
      o_rx_valid <= w_rxValidNext;
      o_busy     <= w_busyNext;
      o_sel_err  <= w_selErrNext;
    end
  end

endmodule

// File: tb/tb_spi_shift_engine.sv
// tb_spi_shift_engine
// Directed bench for spi_shift_engine. The main instance runs with a divide
// of two and MISO looped back from MOSI (or tied high); a second instance
// with a divide of one covers the undivided SCLK case.
module tb_spi_shift_engine;

  localparam int DIV = 2;

  logic       clk = 1'b0;
  logic       rstN;
  logic       start;
  logic [2:0] ssIn;
  logic [7:0] txData;
  logic       misoTie;
  logic       miso;
  logic       sclk, mosi, rxValid, busy, selErr;
  logic [2:0] ssN;
  logic [7:0] rxData;

  logic       start1;
  logic [7:0] txData1;
  logic       sclk1, mosi1, rxValid1, busy1, selErr1;
  logic [2:0] ssN1;
  logic [7:0] rxData1;

  int vecCount  = 0;
  int missCount = 0;

  always #5 clk = ~clk;

  // MISO is either looped back from MOSI or held at one.
  assign miso = misoTie ? 1'b1 : mosi;

  spi_shift_engine #(.CLK_DIV(DIV), .NUM_SLAVES(3)) u_dut (
    .i_clk(clk), .i_rst_n(rstN), .i_start(start), .i_ss_in(ssIn),
    .i_tx_data(txData), .i_miso(miso), .o_sclk(sclk), .o_mosi(mosi),
    .o_ss_n(ssN), .o_rx_data(rxData), .o_rx_valid(rxValid),
    .o_busy(busy), .o_sel_err(selErr)
  );

  spi_shift_engine #(.CLK_DIV(1), .NUM_SLAVES(3)) u_dutDiv1 (
    .i_clk(clk), .i_rst_n(rstN), .i_start(start1), .i_ss_in(3'd2),
    .i_tx_data(txData1), .i_miso(mosi1), .o_sclk(sclk1), .o_mosi(mosi1),
    .o_ss_n(ssN1), .o_rx_data(rxData1), .o_rx_valid(rxValid1),
    .o_busy(busy1), .o_sel_err(selErr1)
  );

  // Single comparison point: counts the vector and reports any miscompare.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Pulse START for one rising edge; returns at the negedge after accept.
  task automatic applyStimulus(input logic [2:0] ss, input logic [7:0] tx);
    @(negedge clk);
    start  = 1'b1;
    ssIn   = ss;
    txData = tx;
    @(negedge clk);
    start  = 1'b0;
    ssIn   = ~ss;
    txData = ~tx;
  endtask

  // One full transfer observed cycle by cycle from the accept edge onward.
  task automatic doTransfer(input string tag, input logic [2:0] ss, input logic [7:0] tx,
                            input logic [7:0] expRx, input logic [2:0] expSsN,
                            input bit injectStart);
    int pulses = 0, highCnt = 0, ssLowCnt = 0, badSs = 0, validCnt = 0, validCyc = -1;
    logic [7:0] mosiSeq = 8'h00;
    logic prevSclk = 1'b0;
    bit injected = 1'b0;
    applyStimulus(ss, tx);
    checkOutput({tag, " accept busy"}, 32'(busy), 32'd1);
    checkOutput({tag, " accept mosi"}, 32'(mosi), 32'(tx[7]));
    for (int c = 0; c < 18 * DIV + 8; c++) begin
      if (c > 0) @(negedge clk);
      start = 1'b0;
      if (sclk && !prevSclk) begin
        pulses++;
        mosiSeq = {mosiSeq[6:0], mosi};
      end
      if (sclk) highCnt++;
      if (ssN != 3'b111) ssLowCnt++;
      if (ssN != 3'b111 && ssN != expSsN) badSs++;
      if (rxValid) begin
        validCnt++;
        validCyc = c;
      end
      if (injectStart && !injected && pulses == 3 && sclk) begin
        start    = 1'b1;
        txData   = 8'hFF;
        ssIn     = 3'b000;
        injected = 1'b1;
      end
      prevSclk = sclk;
    end
    checkOutput({tag, " sclk pulses"}, 32'(pulses), 32'd8);
    checkOutput({tag, " sclk high cycles"}, 32'(highCnt), 32'(8 * DIV));
    checkOutput({tag, " mosi bits"}, 32'(mosiSeq), 32'(tx));
    checkOutput({tag, " ss_n low cycles"}, 32'(ssLowCnt), 32'(18 * DIV));
    checkOutput({tag, " wrong ss_n code"}, 32'(badSs), 32'd0);
    checkOutput({tag, " rx_valid count"}, 32'(validCnt), 32'd1);
    checkOutput({tag, " rx_valid cycle"}, 32'(validCyc), 32'(18 * DIV));
    checkOutput({tag, " rx_data"}, 32'(rxData), 32'(expRx));
    checkOutput({tag, " idle after"}, 32'(busy), 32'd0);
  endtask

  // Step negedges until rx_valid is seen; cyc counts from the current negedge.
  task automatic waitValid(output int cyc);
    cyc = -1;
    for (int i = 0; i < 60; i++) begin
      if (i > 0) @(negedge clk);
      if (rxValid) begin
        cyc = i;
        break;
      end
    end
  endtask

  initial begin
    int pulses, validCnt, cyc, high1, cyc1;
    logic prevSclk;
    rstN = 1'b0; start = 1'b0; ssIn = 3'd0; txData = 8'h00; misoTie = 1'b0;
    start1 = 1'b0; txData1 = 8'h00;
    repeat (2) @(negedge clk);
    checkOutput("reset ss_n", 32'(ssN), 32'h7);
    checkOutput("reset sclk", 32'(sclk), 32'd0);
    checkOutput("reset mosi", 32'(mosi), 32'd0);
    checkOutput("reset rx_data", 32'(rxData), 32'h00);
    checkOutput("reset rx_valid", 32'(rxValid), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset sel_err", 32'(selErr), 32'd0);
    rstN = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] loopback 0xA5 on slave 1");
    doTransfer("A5", 3'b001, 8'hA5, 8'hA5, 3'b101, 1'b0);

    $display("[TB] invalid select codes");
    applyStimulus(3'b111, 8'h55);
    checkOutput("code7 sel_err", 32'(selErr), 32'd1);
    checkOutput("code7 ss_n", 32'(ssN), 32'h7);
    checkOutput("code7 busy", 32'(busy), 32'd0);
    checkOutput("code7 sclk", 32'(sclk), 32'd0);
    @(negedge clk);
    checkOutput("code7 sel_err drop", 32'(selErr), 32'd0);
    checkOutput("code7 still idle", 32'(busy), 32'd0);
    applyStimulus(3'b011, 8'h55);
    checkOutput("code3 sel_err", 32'(selErr), 32'd1);
    checkOutput("code3 busy", 32'(busy), 32'd0);
    checkOutput("code3 rx_data kept", 32'(rxData), 32'hA5);

    $display("[TB] 0x3C with START during pulse 3");
    doTransfer("3C", 3'b010, 8'h3C, 8'h3C, 3'b011, 1'b1);

    $display("[TB] reset during fifth SCLK high phase");
    applyStimulus(3'b001, 8'h5A);
    pulses = 0;
    prevSclk = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (c > 0) @(negedge clk);
      if (sclk && !prevSclk) pulses++;
      prevSclk = sclk;
      if (pulses == 5) break;
    end
    checkOutput("abort reached pulse 5", 32'(pulses), 32'd5);
    rstN = 1'b0;
    #1;
    checkOutput("abort ss_n", 32'(ssN), 32'h7);
    checkOutput("abort sclk", 32'(sclk), 32'd0);
    checkOutput("abort mosi", 32'(mosi), 32'd0);
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort rx_data", 32'(rxData), 32'h00);
    validCnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (rxValid) validCnt++;
    end
    rstN = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (rxValid) validCnt++;
    end
    checkOutput("abort no rx_valid", 32'(validCnt), 32'd0);
    doTransfer("81", 3'b000, 8'h81, 8'h81, 3'b110, 1'b0);

    $display("[TB] MISO tied high, TX 0x00");
    misoTie = 1'b1;
    doTransfer("miso1", 3'b000, 8'h00, 8'hFF, 3'b110, 1'b0);
    misoTie = 1'b0;

    $display("[TB] back-to-back transfers");
    applyStimulus(3'b000, 8'h12);
    checkOutput("b2b first ss_n", 32'(ssN), 32'h6);
    waitValid(cyc);
    checkOutput("b2b first latency", 32'(cyc), 32'(18 * DIV));
    checkOutput("b2b first rx_data", 32'(rxData), 32'h12);
    @(negedge clk);
    checkOutput("b2b idle gap", 32'(busy), 32'd0);
    start  = 1'b1;
    ssIn   = 3'b010;
    txData = 8'h34;
    @(negedge clk);
    start  = 1'b0;
    checkOutput("b2b second busy", 32'(busy), 32'd1);
    checkOutput("b2b second ss_n", 32'(ssN), 32'h3);
    waitValid(cyc);
    checkOutput("b2b second latency", 32'(cyc), 32'(18 * DIV));
    checkOutput("b2b second rx_data", 32'(rxData), 32'h34);

    $display("[TB] undivided SCLK instance");
    @(negedge clk);
    start1  = 1'b1;
    txData1 = 8'hC3;
    @(negedge clk);
    start1  = 1'b0;
    txData1 = 8'h00;
    checkOutput("div1 ss_n", 32'(ssN1), 32'h3);
    high1 = 0;
    cyc1  = -1;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) @(negedge clk);
      if (sclk1) high1++;
      if (rxValid1 && cyc1 < 0) cyc1 = c;
    end
    checkOutput("div1 latency", 32'(cyc1), 32'd18);
    checkOutput("div1 sclk high cycles", 32'(high1), 32'd8);
    checkOutput("div1 rx_data", 32'(rxData1), 32'hC3);
    checkOutput("div1 idle after", 32'(busy1), 32'd0);
    checkOutput("div1 sel_err", 32'(selErr1), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
